// File: rtl/tmr_recovery_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tmr_recovery_pkg                                                 |
// | Shared state encodings, CPU indices and output decode for the TMR          |
// | recovery sequencer and the bus monitor drivers.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tmr_recovery_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_HALT    = 3'd1;
    localparam logic [2:0] c_ST_RESET   = 3'd2;
    localparam logic [2:0] c_ST_RELEASE = 3'd3;
    localparam logic [2:0] c_ST_RESUME  = 3'd4;
    localparam logic [2:0] c_ST_FATAL   = 3'd5;

    localparam logic [1:0] c_CPU0 = 2'd0;
    localparam logic [1:0] c_CPU1 = 2'd1;
    localparam logic [1:0] c_CPU2 = 2'd2;

    typedef enum logic [1:0] {
        FLT_NONE   = 2'd0,
        FLT_SINGLE = 2'd1,
        FLT_MULTI  = 2'd2
    } flt_class_t;

    typedef struct packed {
        logic [2:0] cpu_enable_clk;
        logic [2:0] cpu_reset;
        logic       override_reset_vector;
        logic       reset_to_recovery;
        logic       cpu_back_online;
        logic       busy;
        logic       fatal;
    } seq_out_t;

    // Output pattern that holds for the whole time the sequencer sits in a state.
    function automatic seq_out_t state_outputs(input logic [2:0] state, input logic [1:0] cpu);
        seq_out_t w_out;
        w_out                = '0;
        w_out.cpu_enable_clk = 3'b111;
        case (state)
            c_ST_IDLE: begin
                w_out.cpu_enable_clk = 3'b111;
            end
            c_ST_HALT: begin
                w_out.cpu_enable_clk = 3'b000;
                w_out.busy           = 1'b1;
            end
            c_ST_RESET: begin
                w_out.cpu_enable_clk        = 3'b000;
                w_out.cpu_reset             = 3'b001 << cpu;
                w_out.override_reset_vector = 1'b1;
                w_out.reset_to_recovery     = 1'b1;
                w_out.busy                  = 1'b1;
            end
            c_ST_RELEASE: begin
                w_out.cpu_enable_clk        = 3'b000;
                w_out.override_reset_vector = 1'b1;
                w_out.reset_to_recovery     = 1'b1;
                w_out.busy                  = 1'b1;
            end
            c_ST_RESUME: begin
                w_out.cpu_enable_clk  = 3'b111;
                w_out.cpu_back_online = 1'b1;
                w_out.busy            = 1'b1;
            end
            default: begin
                w_out.cpu_enable_clk = 3'b000;
                w_out.cpu_reset      = 3'b111;
                w_out.fatal          = 1'b1;
            end
        endcase
        return w_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_fault_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tmr_fault_decoder                                                |
// | Classifies the per-CPU disagreement flags as none/single/multi and gives   |
// | the index of the lowest flagged CPU.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tmr_fault_decoder
    import tmr_recovery_pkg::*;
(
    input  logic [2:0] i_flags,
    output flt_class_t o_class,
    output logic [1:0] o_index
);

    logic [1:0] w_pop;

    always_comb begin
        w_pop = 2'(i_flags[0]) + 2'(i_flags[1]) + 2'(i_flags[2]);

        case (w_pop)
            2'd0:    o_class = FLT_NONE;
            2'd1:    o_class = FLT_SINGLE;
            default: o_class = FLT_MULTI;
        endcase

        if (i_flags[0]) begin
            o_index = c_CPU0;
        end else if (i_flags[1]) begin
            o_index = c_CPU1;
        end else if (i_flags[2]) begin
            o_index = c_CPU2;
        end else begin
            o_index = c_CPU0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmr_recovery_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tmr_recovery_sequencer                                           |
// | Hardware recovery of a single faulty CPU in a TMR triplet: halt, reset to  |
// | the recovery vector, release, resume, and handshake with the bus monitor.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tmr_recovery_sequencer
    import tmr_recovery_pkg::*;
#(
    parameter int HALT_CYCLES    = 16,
    parameter int RESET_CYCLES   = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_areset,
    input  logic             enable,
    input  logic [2:0]       bus_invalid,
    input  logic [2:0]       actual_cpu_reset,
    input  logic             ack_back_online,
    output logic [2:0]       cpu_enable_clk,
    output logic [2:0]       cpu_reset,
    output logic             override_reset_vector,
    output logic             reset_to_recovery,
    output logic             cpu_back_online,
    output logic             busy,
    output logic             fatal,
    output logic [1:0]       faulty_cpu,
    output logic [CNT_W-1:0] recovery_count
);

    localparam int              c_CW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_HALT_LEN    = c_CW'(HALT_CYCLES);
    localparam logic [c_CW-1:0] c_RESET_LEN   = c_CW'(RESET_CYCLES);
    localparam logic [c_CW-1:0] c_TIMEOUT_LEN = c_CW'(TIMEOUT_CYCLES);

    logic [2:0]       r_flags;
    flt_class_t       w_class;
    logic [1:0]       w_index;
    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_elapsed;
    logic             w_timeout;
    logic [2:0]       w_act_shift;
    logic             w_act_reset;
    logic [1:0]       r_faulty;
    logic [1:0]       w_faulty_next;
    seq_out_t         r_out;
    logic [CNT_W-1:0] r_count;

    tmr_fault_decoder u_decoder (
        .i_flags (r_flags),
        .o_class (w_class),
        .o_index (w_index)
    );

    // w_elapsed counts the current cycle, so a state lasts exactly N cycles
    // when the exit test is w_elapsed >= N.
    always_comb begin
        w_elapsed   = r_cnt + c_CW'(1);
        w_timeout   = (w_elapsed >= c_TIMEOUT_LEN);
        w_act_shift = actual_cpu_reset >> r_faulty;
        w_act_reset = w_act_shift[0];
        w_next      = r_state;

        case (r_state)
            c_ST_IDLE: begin
                if (enable && (w_class == FLT_SINGLE)) begin
                    w_next = c_ST_HALT;
                end else if (enable && (w_class == FLT_MULTI)) begin
                    w_next = c_ST_FATAL;
                end
            end
            c_ST_HALT: begin
                if (w_elapsed >= c_HALT_LEN) begin
                    w_next = c_ST_RESET;
                end
            end
            c_ST_RESET: begin
                if ((w_elapsed >= c_RESET_LEN) && w_act_reset) begin
                    w_next = c_ST_RELEASE;
                end else if (w_timeout) begin
                    w_next = c_ST_FATAL;
                end
            end
            c_ST_RELEASE: begin
                if (!w_act_reset) begin
                    w_next = c_ST_RESUME;
                end else if (w_timeout) begin
                    w_next = c_ST_FATAL;
                end
            end
            c_ST_RESUME: begin
                if (ack_back_online) begin
                    w_next = c_ST_IDLE;
                end else if (w_timeout) begin
                    w_next = c_ST_FATAL;
                end
            end
            default: begin
                w_next = c_ST_FATAL;
            end
        endcase

        w_faulty_next = ((r_state == c_ST_IDLE) && (w_next == c_ST_HALT)) ? w_index : r_faulty;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_flags  <= 3'b000;
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_faulty <= c_CPU0;
            r_out    <= state_outputs(c_ST_IDLE, c_CPU0);
            r_count  <= '0;
        end else begin
            r_flags  <= bus_invalid;
            r_state  <= w_next;
            r_faulty <= w_faulty_next;
            r_out    <= state_outputs(w_next, w_faulty_next);

            if ((w_next != r_state) || (w_next == c_ST_IDLE) || (w_next == c_ST_FATAL)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_elapsed;
            end

            if ((r_state == c_ST_RESUME) && (w_next == c_ST_IDLE) && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign cpu_enable_clk        = r_out.cpu_enable_clk;
    assign cpu_reset             = r_out.cpu_reset;
    assign override_reset_vector = r_out.override_reset_vector;
    assign reset_to_recovery     = r_out.reset_to_recovery;
    assign cpu_back_online       = r_out.cpu_back_online;
    assign busy                  = r_out.busy;
    assign fatal                 = r_out.fatal;
    assign faulty_cpu            = r_faulty;
    assign recovery_count        = r_count;

endmodule
`default_nettype wire
